flag_cond_unit: RTL and testbench
=================================

FLAG_COND_UNIT -- requirements
Module: flag_cond_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset_n  in  1  asynchronous active-low reset; 0 clears all state immediately.
REQ-004 zero, negative, carry_out, overflow  in  1 each  EX-stage ALU flags, combinational from the flag logic.
REQ-005 ex_valid  in  1  EX stage holds a live instruction.
REQ-006 ex_set_flags  in  1  EX instruction writes NZCV (ADDS/SUBS/ANDS).
REQ-007 id_valid  in  1  ID stage holds a live instruction.
REQ-008 id_is_bcond  in  1  ID instruction is B.cond.
REQ-009 id_is_cbz  in  1  ID instruction is CBZ.
REQ-010 id_cond  in  4  B.cond condition code.
REQ-011 id_reg_zero  in  1  CBZ operand is all zeros.
REQ-012 stall  in  1  pipeline hold; ID and EX do not advance.
REQ-013 flush  in  1  kills the ID instruction this cycle.
REQ-014 flags_q  out  4  architectural NZCV, order {N,Z,C,V}.
REQ-015 br_valid  out  1  registered branch decision valid, one-cycle pulse.
REQ-016 br_taken  out  1  registered branch decision; meaningful only when br_valid=1.

Function
REQ-017 flag_we SHALL equal ex_valid & ex_set_flags & ~stall; on flag_we, flags_q SHALL load {negative,zero,carry_out,overflow} at the next edge; otherwise flags_q SHALL hold.
REQ-018 The effective flags (eff) SHALL be the ALU flags when ex_valid & ex_set_flags, else flags_q. This is combinational forwarding and introduces no bubble.
REQ-019 The conditions SHALL be evaluated on eff. EQ(0000) Z; NE ~Z; HS(0010) C; LO ~C; MI(0100) N; PL ~N; VS(0110) V; VC ~V; HI(1000) C&~Z; LS ~(C&~Z); GE(1010) N==V; LT N!=V; GT(1100) ~Z&(N==V); LE ~GT; 1110 and 1111 always true.
REQ-020 A decision SHALL be accepted when id_valid & (id_is_bcond | id_is_cbz) & ~stall & ~flush.
REQ-021 The taken value for B.cond SHALL be cond_true; for CBZ it SHALL be id_reg_zero, independent of flags.
REQ-022 If both id_is_bcond and id_is_cbz are set, CBZ SHALL take priority.
REQ-023 On an accepted decision, br_valid SHALL be 1 and br_taken SHALL be the taken value at the next edge, giving a latency of 1 cycle.
REQ-024 When no decision is accepted, br_valid SHALL be 0 at the next edge and br_taken SHALL hold its previous value.
REQ-025 stall SHALL freeze flags_q and suppress acceptance. br_valid SHALL drop to 0 after one cycle, so a stalled B.cond produces exactly one decision when stall releases.
REQ-026 Decision state is a 2-state FSM: IDLE (br_valid=0) and RESOLVED (br_valid=1). IDLE goes to RESOLVED on accept. RESOLVED goes to RESOLVED on accept, else to IDLE.
REQ-027 flush SHALL block ID acceptance only; the EX flag write under REQ-017 SHALL proceed.
REQ-028 Simultaneous flag write and B.cond accept SHALL evaluate on the new (forwarded) flags; flags_q SHALL update in the same edge.
REQ-029 Back-to-back flag setters SHALL each update flags_q, and the last one wins.
REQ-030 ex_valid=0 SHALL never change flags_q, regardless of ex_set_flags.

Reset
REQ-031 While reset_n=0: flags_q=4'b0000, br_valid=0, br_taken=0, FSM=IDLE, asynchronously and regardless of clk.
REQ-032 Reset asserted mid-operation SHALL discard any pending decision and flag update. The first edge after release with valid inputs SHALL behave as from power-up.
REQ-033 After release, B.cond evaluations SHALL use flags 0000 until the first flag write: EQ not taken, NE taken.

Verification
REQ-034 SUBS with result 0 (Z=1,N=0,C=1,V=0) in EX, same cycle as B.EQ in ID, no stall: next cycle flags_q=0110, br_valid=1, br_taken=1.
REQ-035 flags_q=1000 (N=1,V=0), no EX setter, B.LT then B.GE on consecutive cycles: br_taken 1 then 0, br_valid high both cycles.
REQ-036 ADDS in EX with stall=1 for 2 cycles, B.NE in ID: flags_q unchanged and br_valid=0 during the stall. On release, one br_valid pulse and the flags update.
REQ-037 CBZ with id_reg_zero=1 and flags_q=0000, with a flush in the first cycle, then re-presented: no decision in the flush cycle, then br_valid=1, br_taken=1.
REQ-038 reset_n driven low mid-cycle while br_valid=1 and flags_q=1111: outputs go to 0 before the next edge. B.AL after release gives br_taken=1.
REQ-039 Sweep all 16 id_cond values against all 16 flag combinations held in flags_q and compare with the REQ-019 table. This is 256 checks, all matching.

Source files
------------

// File: rtl/flag_cond_if.sv
// Bundle of EX-stage flag inputs, ID-stage branch inputs, pipeline controls
// and the registered flag/branch outputs of flag_cond_unit.
interface flag_cond_if;
  // EX stage ALU flags and flag-write qualifiers
  logic       zero;
  logic       negative;
  logic       carry_out;
  logic       overflow;
  logic       ex_valid;
  logic       ex_set_flags;
  // ID stage branch description
  logic       id_valid;
  logic       id_is_bcond;
  logic       id_is_cbz;
  logic [3:0] id_cond;
  logic       id_reg_zero;
  // pipeline control
  logic       stall;
  logic       flush;
  // results
  logic [3:0] flags_q;
  logic       br_valid;
  logic       br_taken;

  // pipeline side: drives the stage inputs, observes the results
  modport master (
    output zero, negative, carry_out, overflow, ex_valid, ex_set_flags,
    output id_valid, id_is_bcond, id_is_cbz, id_cond, id_reg_zero,
    output stall, flush,
    input  flags_q, br_valid, br_taken
  );

  // flag/condition unit side
  modport slave (
    input  zero, negative, carry_out, overflow, ex_valid, ex_set_flags,
    input  id_valid, id_is_bcond, id_is_cbz, id_cond, id_reg_zero,
    input  stall, flush,
    output flags_q, br_valid, br_taken
  );
endinterface

// File: rtl/flag_cond_unit.sv
// NZCV flag register with EX->ID forwarding and a one-cycle registered
// branch resolver for B.cond and CBZ.
module flag_cond_unit (
  input  logic        clk,
  input  logic        reset_n,
  flag_cond_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, RESOLVED = 1'b1} dec_state_t;

  logic [3:0] flags_r;
  logic [3:0] alu_nzcv;
  logic [3:0] eff;
  logic       ex_setter;
  logic       flag_we;
  logic       cond_true;
  logic       accept;
  logic       taken;
  dec_state_t state;
  logic       br_valid_r;
  logic       br_taken_r;

  // flags travel as {N,Z,C,V} everywhere
  assign alu_nzcv  = {bus.negative, bus.zero, bus.carry_out, bus.overflow};
  assign ex_setter = bus.ex_valid & bus.ex_set_flags;
  // flush only kills ID; a stall holds EX so the write waits with it
  assign flag_we   = ex_setter & ~bus.stall;
  // forward the setter's flags so a B.cond right behind it needs no bubble,
  // even while stalled, since acceptance is blocked then anyway
  assign eff       = ex_setter ? alu_nzcv : flags_r;

  // condition-code evaluation on the effective flags
  always_comb begin
    cond_true = 1'b0;
    unique case (bus.id_cond)
      4'b0000: cond_true =  eff[2];                          // EQ
      4'b0001: cond_true = ~eff[2];                          // NE
      4'b0010: cond_true =  eff[1];                          // HS
      4'b0011: cond_true = ~eff[1];                          // LO
      4'b0100: cond_true =  eff[3];                          // MI
      4'b0101: cond_true = ~eff[3];                          // PL
      4'b0110: cond_true =  eff[0];                          // VS
      4'b0111: cond_true = ~eff[0];                          // VC
      4'b1000: cond_true =  eff[1] & ~eff[2];                // HI
      4'b1001: cond_true = ~(eff[1] & ~eff[2]);              // LS
      4'b1010: cond_true =  (eff[3] == eff[0]);              // GE
      4'b1011: cond_true =  (eff[3] != eff[0]);              // LT
      4'b1100: cond_true = ~eff[2] & (eff[3] == eff[0]);     // GT
      4'b1101: cond_true = ~(~eff[2] & (eff[3] == eff[0]));  // LE
      default: cond_true = 1'b1;                             // AL / NV
    endcase
  end

  // CBZ wins when both decode bits are set; it ignores the flags entirely
  assign accept = bus.id_valid & (bus.id_is_bcond | bus.id_is_cbz) &
                  ~bus.stall & ~bus.flush;
  assign taken  = bus.id_is_cbz ? bus.id_reg_zero : cond_true;

  // architectural NZCV register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     flags_r <= 4'b0000;
    else if (flag_we) flags_r <= alu_nzcv;
  end

  // decision FSM: RESOLVED marks a fresh decision, br_taken holds otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      br_valid_r <= 1'b0;
      br_taken_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state      <= RESOLVED;
            br_valid_r <= 1'b1;
            br_taken_r <= taken;
          end else begin
            br_valid_r <= 1'b0;
          end
        end
        RESOLVED: begin
          if (accept) begin
            state      <= RESOLVED;
            br_valid_r <= 1'b1;
            br_taken_r <= taken;
          end else begin
            state      <= IDLE;
            br_valid_r <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          br_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.flags_q  = flags_r;
  assign bus.br_valid = br_valid_r;
  assign bus.br_taken = br_taken_r;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed bench for flag_cond_unit: reset, forwarding, stall, flush,
// CBZ priority, async reset and a full condition-code sweep.
module tb_flag_cond_unit;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  flag_cond_if bus ();

  flag_cond_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count one comparison, report a mismatch
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // reference condition table, grouped by condition pair
  function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, b;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0: b = z;
      3'd1: b = c;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = c & ~z;
      3'd5: b = (n == v);
      3'd6: b = ~z & (n == v);
      default: return 1'b1;
    endcase
    return b ^ cond[0];
  endfunction

  task automatic idle();
    {bus.negative, bus.zero, bus.carry_out, bus.overflow} = 4'b0000;
    bus.ex_valid = 0; bus.ex_set_flags = 0;
    bus.id_valid = 0; bus.id_is_bcond = 0; bus.id_is_cbz = 0;
    bus.id_cond = 4'b0000; bus.id_reg_zero = 0;
    bus.stall = 0; bus.flush = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // EX setter with {N,Z,C,V}
  task automatic ex_set(input logic [3:0] nzcv);
    {bus.negative, bus.zero, bus.carry_out, bus.overflow} = nzcv;
    bus.ex_valid = 1; bus.ex_set_flags = 1;
  endtask

  task automatic bcond(input logic [3:0] cond);
    bus.id_valid = 1; bus.id_is_bcond = 1; bus.id_is_cbz = 0; bus.id_cond = cond;
  endtask

  initial begin
    checks = 0; errors = 0;
    idle();
    reset_n = 0;
    #12;
    chk("rst_flags", bus.flags_q, 4'b0000);
    chk("rst_bv", {3'b0, bus.br_valid}, 4'd0);
    chk("rst_bt", {3'b0, bus.br_taken}, 4'd0);
    @(negedge clk); reset_n = 1;
    step();

    // flags 0000 after reset: EQ not taken, NE taken
    bcond(4'b0000); step();
    chk("pwr_eq_bv", {3'b0, bus.br_valid}, 4'd1);
    chk("pwr_eq_bt", {3'b0, bus.br_taken}, 4'd0);
    bcond(4'b0001); step();
    chk("pwr_ne_bt", {3'b0, bus.br_taken}, 4'd1);
    idle(); step();
    chk("idle_bv", {3'b0, bus.br_valid}, 4'd0);
    chk("idle_bt_hold", {3'b0, bus.br_taken}, 4'd1);

    // SUBS result 0 forwarded to B.EQ in the same cycle
    ex_set(4'b0110); bcond(4'b0000); step();
    chk("fwd_flags", bus.flags_q, 4'b0110);
    chk("fwd_bv", {3'b0, bus.br_valid}, 4'd1);
    chk("fwd_bt", {3'b0, bus.br_taken}, 4'd1);

    // back-to-back setters, last one wins; then B.LT / B.GE on 1000
    idle(); ex_set(4'b0001); step();
    chk("b2b_1", bus.flags_q, 4'b0001);
    ex_set(4'b1000); step();
    chk("b2b_2", bus.flags_q, 4'b1000);
    chk("b2b_bv", {3'b0, bus.br_valid}, 4'd0);
    idle(); bcond(4'b1011); step();
    chk("lt_bv", {3'b0, bus.br_valid}, 4'd1);
    chk("lt_bt", {3'b0, bus.br_taken}, 4'd1);
    bcond(4'b1010); step();
    chk("ge_bv", {3'b0, bus.br_valid}, 4'd1);
    chk("ge_bt", {3'b0, bus.br_taken}, 4'd0);

    // ADDS with stall for 2 cycles, B.NE waiting in ID
    ex_set(4'b0011); bcond(4'b0001); bus.stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_flags", bus.flags_q, 4'b1000);
      chk("stall_bv", {3'b0, bus.br_valid}, 4'd0);
    end
    bus.stall = 0; step();
    chk("rel_flags", bus.flags_q, 4'b0011);
    chk("rel_bv", {3'b0, bus.br_valid}, 4'd1);
    chk("rel_bt", {3'b0, bus.br_taken}, 4'd1);
    idle(); step();
    chk("rel_once", {3'b0, bus.br_valid}, 4'd0);

    // flush kills CBZ but the EX write still happens
    ex_set(4'b0000); step();
    chk("zero_flags", bus.flags_q, 4'b0000);
    idle();
    ex_set(4'b0101);
    bus.id_valid = 1; bus.id_is_cbz = 1; bus.id_reg_zero = 1; bus.flush = 1;
    step();
    chk("flush_bv", {3'b0, bus.br_valid}, 4'd0);
    chk("flush_flags", bus.flags_q, 4'b0101);
    bus.flush = 0; bus.ex_valid = 0; step();
    chk("cbz_bv", {3'b0, bus.br_valid}, 4'd1);
    chk("cbz_bt", {3'b0, bus.br_taken}, 4'd1);
    // CBZ priority over B.cond: EQ false on Z=1? flags 0101 has Z=1, use NE
    bus.id_is_bcond = 1; bus.id_cond = 4'b0001; bus.id_reg_zero = 1; step();
    chk("prio_bt1", {3'b0, bus.br_taken}, 4'd1);
    bus.id_cond = 4'b0000; bus.id_reg_zero = 0; step();
    chk("prio_bt0", {3'b0, bus.br_taken}, 4'd0);
    // ex_valid low never writes flags
    idle(); {bus.negative, bus.zero, bus.carry_out, bus.overflow} = 4'b1010;
    bus.ex_set_flags = 1; step();
    chk("exv0_flags", bus.flags_q, 4'b0101);

    // async reset mid-cycle while br_valid=1 and flags=1111
    idle(); ex_set(4'b1111); bcond(4'b1110); step();
    chk("pre_rst_flags", bus.flags_q, 4'b1111);
    chk("pre_rst_bv", {3'b0, bus.br_valid}, 4'd1);
    #2 reset_n = 0;
    #1;
    chk("arst_flags", bus.flags_q, 4'b0000);
    chk("arst_bv", {3'b0, bus.br_valid}, 4'd0);
    chk("arst_bt", {3'b0, bus.br_taken}, 4'd0);
    step();
    chk("arst_hold_flags", bus.flags_q, 4'b0000);
    chk("arst_hold_bv", {3'b0, bus.br_valid}, 4'd0);
    @(negedge clk); reset_n = 1;
    idle(); bcond(4'b1110); step();
    chk("al_bv", {3'b0, bus.br_valid}, 4'd1);
    chk("al_bt", {3'b0, bus.br_taken}, 4'd1);
    chk("al_flags", bus.flags_q, 4'b0000);

    // condition sweep against every held flag pattern
    for (int f = 0; f < 16; f++) begin
      idle(); ex_set(f[3:0]); step();
      chk("sweep_load", bus.flags_q, f[3:0]);
      idle();
      for (int c = 0; c < 16; c++) begin
        bcond(c[3:0]); step();
        chk($sformatf("sweep_f%0d_c%0d", f, c), {3'b0, bus.br_taken},
            {3'b0, ref_cond(c[3:0], f[3:0])});
      end
    end

    idle(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
